// File: rtl/function_pkg.sv
// Shared constants and FSM state type for the add/shift/multiply-by-3 function
// datapath and its sequential inverse.
//   SUM_W   : width of the forward sum
//   IN_W    : width of the forward result; also the number of divide iterations
//   DIVISOR : forward multiplier, divided out by the inverse
//   SHIFT   : forward left-shift applied when condition = 0
package function_pkg;

    localparam int unsigned SUM_W   = 4;
    localparam int unsigned IN_W    = 2 * SUM_W;
    localparam int unsigned DIVISOR = 3;
    localparam int unsigned SHIFT   = 2;

    // Remainder is always < DIVISOR; one extra bit holds the shifted-in trial value.
    localparam int unsigned REM_W   = $clog2(DIVISOR) + 1;
    localparam int unsigned CNT_W   = $clog2(IN_W);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_e;

endpackage

// File: rtl/restoring_div_step.sv
// One combinational iteration of restoring division by a constant.
//   i_rem  : partial remainder from the previous iteration (always < DIVISOR)
//   i_bit  : next dividend bit, MSB first
//   o_rem  : partial remainder after this iteration
//   o_qbit : quotient bit produced by this iteration
module restoring_div_step #(
    parameter int unsigned REM_W   = 3,
    parameter int unsigned DIVISOR = 3
) (
    input  logic [REM_W-1:0] i_rem,
    input  logic             i_bit,
    output logic [REM_W-1:0] o_rem,
    output logic             o_qbit
);

    localparam logic [REM_W-1:0] DivL = DIVISOR[REM_W-1:0];

    logic [REM_W-1:0] w_trial;

    // i_rem < DIVISOR leaves its MSB clear, so {rem, bit} fits in REM_W bits.
    // A set MSB can only come from a corrupted remainder; forcing a subtract
    // then keeps the step well-defined.
    assign w_trial = {i_rem[REM_W-2:0], i_bit};

    always_comb begin
        o_qbit = i_rem[REM_W-1] || (w_trial >= DivL);
        o_rem  = o_qbit ? (w_trial - DivL) : w_trial;
    end

endmodule

// File: rtl/hardware_function_inverse.sv
// Sequential inverse of the add/shift/multiply-by-3 function datapath.
// Divides the forward result by DIVISOR one bit per cycle (restoring, MSB
// first), undoes the optional left shift, and flags results the forward
// function cannot produce.
//   clock, reset          : rising-edge clock, async active-low reset
//   io_in_valid/ready     : input handshake; ready only in IDLE
//   io_in_data            : forward final result (sampled at accept)
//   io_in_condition       : forward condition bit, 1 = unshifted path
//   io_out_valid/ready    : output handshake; result held until accepted
//   io_out_sum            : recovered sum
//   io_out_error          : input not producible by the forward function
module hardware_function_inverse
    import function_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [IN_W-1:0]  io_in_data,
    input  logic             io_in_condition,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [SUM_W-1:0] io_out_sum,
    output logic             io_out_error
);

    state_e           r_state;
    // Dividend shifts out of the top while quotient bits shift in at the
    // bottom; after IN_W steps the register holds the full quotient.
    logic [IN_W-1:0]  r_work;
    logic [REM_W-1:0] r_rem;
    logic [CNT_W-1:0] r_count;
    logic             r_cond;
    logic             r_out_valid;
    logic [SUM_W-1:0] r_out_sum;
    logic             r_out_error;

    logic [REM_W-1:0] w_rem_next;
    logic             w_qbit;
    logic [IN_W-1:0]  w_quot;
    logic [SUM_W-1:0] w_sum;
    logic             w_error;

    restoring_div_step #(
        .REM_W   (REM_W),
        .DIVISOR (DIVISOR)
    ) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_work[IN_W-1]),
        .o_rem  (w_rem_next),
        .o_qbit (w_qbit)
    );

    assign w_quot = {r_work[IN_W-2:0], w_qbit};

    // Recovery and producibility check on the quotient of the final step.
    always_comb begin
        w_sum   = r_cond ? w_quot[SUM_W-1:0] : w_quot[SHIFT +: SUM_W];
        w_error = (w_rem_next != '0)
               || (w_quot[IN_W-1:SUM_W+SHIFT] != '0)
               || (r_cond ? (w_quot[SUM_W+SHIFT-1:SUM_W] != '0)
                          : (w_quot[SHIFT-1:0] != '0));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_cond      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_in_valid) begin
                        r_work  <= io_in_data;
                        r_rem   <= '0;
                        r_count <= '0;
                        r_cond  <= io_in_condition;
                        r_state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    r_work  <= w_quot;
                    r_rem   <= w_rem_next;
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(IN_W - 1)) begin
                        r_out_valid <= 1'b1;
                        r_out_sum   <= w_sum;
                        r_out_error <= w_error;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (io_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_in_ready  = (r_state == IDLE);
    assign io_out_valid = r_out_valid;
    assign io_out_sum   = r_out_sum;
    assign io_out_error = r_out_error;

endmodule

// File: tb/tb_hardware_function_inverse.sv
// Self-checking bench for hardware_function_inverse. Expected results come from
// a reference model that divides by 3 for the sum and searches the forward
// function for producibility; they are queued at stimulus time and popped when
// the DUT presents a result.
module tb_hardware_function_inverse;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       io_in_valid = 1'b0;
    logic       io_in_ready;
    logic [7:0] io_in_data = '0;
    logic       io_in_condition = 1'b0;
    logic       io_out_valid;
    logic       io_out_ready = 1'b0;
    logic [3:0] io_out_sum;
    logic       io_out_error;

    hardware_function_inverse u_dut (
        .clock           (clock),
        .reset           (reset),
        .io_in_valid     (io_in_valid),
        .io_in_ready     (io_in_ready),
        .io_in_data      (io_in_data),
        .io_in_condition (io_in_condition),
        .io_out_valid    (io_out_valid),
        .io_out_ready    (io_out_ready),
        .io_out_sum      (io_out_sum),
        .io_out_error    (io_out_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] sum;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Sum from q = d/3 sliced per condition; error iff no 4-bit sum maps to d.
    function automatic exp_t model(input logic [7:0] d, input logic c);
        exp_t       e;
        logic [7:0] qv;
        int         f;
        qv    = 8'(int'(d) / 3);
        e.sum = c ? qv[3:0] : qv[5:2];
        e.err = 1'b1;
        for (int s = 0; s < 16; s++) begin
            f = c ? (s * 3) : ((s * 4) * 3);
            if (f == int'(d)) e.err = 1'b0;
        end
        return e;
    endfunction

    // Offer a word and hold it until it is accepted; returns 1 ns after the
    // accepting edge.
    task automatic offer(input logic [7:0] d, input logic c, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (io_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            io_in_data      = d;
            io_in_condition = c;
            io_in_valid     = 1'b1;
            sb.push_back(model(d, c));
            @(posedge clock);
            #1;
            io_in_valid     = 1'b0;
            io_in_data      = 8'hxx;
            io_in_condition = 1'bx;
        end
    endtask

    // Count edges until io_out_valid, sampled 1 ns after each edge.
    task automatic wait_out(output logic ok, output int cycles);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            cycles++;
            if (io_out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain();
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0 || io_out_sum !== 4'd0
            || io_out_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b sum=%0d err=%b, want 1 0 0 0",
                     io_in_ready, io_out_valid, io_out_sum, io_out_error);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_vectors();
        logic [7:0] vd[8] = '{8'd15, 8'd60, 8'd0, 8'd0, 8'd16, 8'd51, 8'd255, 8'd3};
        logic       vc[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       ok;
        int         cyc;
        exp_t       e;
        for (int i = 0; i < 8; i++) begin
            offer(vd[i], vc[i], ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL accept_%0d: in_ready never 1, want 1", vd[i]);
                sb.delete();
                continue;
            end
            wait_out(ok, cyc);
            checks++;
            if (!ok || cyc != 8) begin
                errors++;
                $display("FAIL latency_%0d: got %0d cycles (valid=%b), want 8",
                         vd[i], cyc, ok);
            end
            e = sb.pop_front();
            if (ok) begin
                checks++;
                if (io_out_sum !== e.sum || io_out_error !== e.err) begin
                    errors++;
                    $display("FAIL result_%0d_c%0b: got sum=%0d err=%b, want sum=%0d err=%b",
                             vd[i], vc[i], io_out_sum, io_out_error, e.sum, e.err);
                end
                drain();
                checks++;
                if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_%0d: got ready=%b valid=%b, want 1 0",
                             vd[i], io_in_ready, io_out_valid);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        int   cyc;
        exp_t e;
        int   bad;
        offer(8'd90, 1'b1, ok);
        wait_out(ok, cyc);
        e = sb.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_valid: got valid=0 after %0d cycles, want 1", cyc);
            return;
        end
        io_in_valid     = 1'b1;
        io_in_data      = 8'd6;
        io_in_condition = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (io_out_valid !== 1'b1 || io_out_sum !== e.sum || io_out_error !== e.err
                || io_in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable cycles (sum=%0d err=%b), want 0 (sum=%0d err=%b)",
                     bad, io_out_sum, io_out_error, e.sum, e.err);
        end
        io_in_valid = 1'b0;
        drain();
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_no_accept: got %0d busy cycles after drain, want 0", bad);
        end
    endtask

    task automatic test_reset_mid_divide();
        logic ok;
        int   cyc;
        exp_t e;
        int   bad;
        offer(8'd255, 1'b1, ok);
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        void'(sb.pop_back());
        #1;
        checks++;
        if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0 || io_out_sum !== 4'd0
            || io_out_error !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got ready=%b valid=%b sum=%0d err=%b, want 1 0 0 0",
                     io_in_ready, io_out_valid, io_out_sum, io_out_error);
        end
        @(negedge clock);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (io_out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stale_result: got valid on %0d cycles, want 0", bad);
        end
        offer(8'd3, 1'b1, ok);
        wait_out(ok, cyc);
        e = sb.pop_front();
        checks++;
        if (!ok || cyc != 8 || io_out_sum !== e.sum || io_out_error !== e.err) begin
            errors++;
            $display("FAIL post_reset_3: got valid=%b cyc=%0d sum=%0d err=%b, want 1 8 %0d %b",
                     ok, cyc, io_out_sum, io_out_error, e.sum, e.err);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_divide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hardware_function_inverse.md
Name: hardware_function_inverse

Overview:
- Sequential inverse of the team's add/shift/multiply-by-3 function datapath.
- Takes a full 8-bit final result and the condition bit that produced it.
- Recovers the 4-bit sum by iterative restoring division by 3, then undoes the optional left shift by 2.
- Flags any input that the forward function cannot have produced. Sits on the checker/readback side of the function block, with valid/ready on both ends.

Parameters:
- SUM_W, 4, width of recovered sum.
- IN_W, 8, input width (2*SUM_W); also the number of divide iterations.
- DIVISOR, 3, constant divisor (forward multiplier).
- SHIFT, 2, forward left-shift amount undone when condition=0.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- io_in_valid  in  1  input word valid.
- io_in_ready  out  1  block can accept a word.
- io_in_data  in  IN_W  forward final result.
- io_in_condition  in  1  forward condition bit (1 = unshifted path).
- io_out_valid  out  1  result valid.
- io_out_ready  in  1  consumer accepts result.
- io_out_sum  out  SUM_W  recovered sum.
- io_out_error  out  1  input not producible by forward function.

Behaviour:
- FSM states: IDLE, DIVIDE, DONE.
- Reset (async, reset=0): state=IDLE, quotient/remainder/count/condition regs=0, io_out_valid=0, io_out_sum=0, io_out_error=0. io_in_ready = (state==IDLE), so it is 1 during and after reset.
- IDLE: io_in_ready=1. On io_in_valid&io_in_ready:
  - Load dividend=io_in_data; remainder=0; count=0; latch condition.
  - Go to DIVIDE.
- DIVIDE: io_in_ready=0, one quotient bit per cycle, MSB first:
  - r' = {r, next dividend bit}; if r' >= DIVISOR then r' -= DIVISOR and qbit=1, else qbit=0.
  - Remainder register width clog2(DIVISOR)+1 (3 bits); quotient register width IN_W.
  - After IN_W iterations, go to DONE.
  - Latency: accept at edge k, io_out_valid=1 after edge k+IN_W (8 cycles).
- DONE: io_out_valid=1; io_out_sum and io_out_error stable.
  - Stay in DONE while io_out_ready=0.
  - On io_out_ready=1, go to IDLE (io_out_valid=0 the next cycle). No new input is accepted in the same cycle; minimum throughput is one word per IN_W+2 cycles.
- Sum recovery from quotient q:
  - condition=1: sum=q[3:0].
  - condition=0: sum=q[5:2].
- io_out_error=1 if any of:
  - final remainder != 0;
  - q[7:6] != 0, i.e. q exceeds the 6-bit selected range;
  - condition=1 and q[5:4] != 0;
  - condition=0 and q[1:0] != 0.
- On error, io_out_sum still carries the recovery formula value.
- io_in_data and io_in_condition are sampled only at accept; later changes are ignored.
- Reset mid-DIVIDE or mid-DONE: the in-flight word is discarded and the block returns to IDLE; no output handshake occurs.
- Input edge cases: io_in_data=0 gives sum=0, error=0 for either condition. io_in_data=255 takes the full IN_W cycles like any other value; there is no early termination.

Decomposition:
- Shared package (function_pkg): SUM_W, IN_W, DIVISOR, SHIFT constants; FSM state enum {IDLE, DIVIDE, DONE}. The forward function block reuses the constants.
- One natural sub-module, restoring_div_step: combinational single-iteration step (remainder in, dividend bit in → remainder out, quotient bit out).
- FSM, counters and recovery/check logic live in the top module.

Test Plan:
- in=15, cond=1 → after 8 cycles out_valid; sum=5, error=0. Then out_ready=1 → IDLE, in_ready=1 the next cycle.
- in=60, cond=0 → sum=5, error=0. Also in=0 with cond=0 and with cond=1 → sum=0, error=0 both times.
- in=16, cond=1 → remainder 1 → error=1, sum=5. in=51, cond=1 (q=17) → error=1, sum=1.
- in=255, cond=0 → q=85 → error=1, sum=5. Confirm out_valid rises exactly 8 cycles after accept.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → out_valid, sum, error stable; in_ready=0 throughout; a valid input offered meanwhile is not accepted.
- Assert reset=0 on the 4th DIVIDE cycle → all outputs return to reset values immediately (async). After release, a new input (in=3, cond=1) → sum=1, error=0, and no stale result appears.
